// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM states, fault
// data default and the helper that sizes the memory word index.
package imem_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    localparam int REQ_LOAD  = 0;
    localparam int REQ_FETCH = 1;

    function automatic int word_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester is granted at once;
// on a tie the requester not granted most recently wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester that wins a tie; requester 0 first after reset.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                prio_d = 1'b1;
            end else if (gnt[1]) begin
                prio_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory shared by the program loader and the fetch
// stage; loads only until the image is complete, then round-robin.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | loader owns the memory, fetches are held off (not dropped)
// ST_RUN  | loader and fetch share the port round-robin; left only by reset
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_req,
    input  logic [31:0]                   fetch_addr,
    output logic                          fetch_gnt,
    output logic                          fetch_rvalid,
    output logic [31:0]                   fetch_rdata,
    output logic                          fetch_err,
    input  logic                          load_req,
    input  logic [31:0]                   load_addr,
    input  logic [31:0]                   load_wdata,
    output logic                          load_gnt,
    input  logic                          load_done,
    output logic                          running,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [word_idx_w(DEPTH)-1:0]  mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata
);

    localparam int AW = word_idx_w(DEPTH);

    imem_state_t state_q;
    imem_state_t state_d;
    logic        pend_q;
    logic        pend_d;
    logic        pend_err_q;
    logic        pend_err_d;

    logic        arb_en;
    logic [1:0]  arb_req;
    logic [1:0]  arb_gnt;
    logic        fetch_ok;
    logic        load_ok;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
    endfunction

    assign fetch_ok = addr_ok(fetch_addr);
    assign load_ok  = addr_ok(load_addr);

    // The arbiter only sees RUN-state traffic, so boot-time loads leave the
    // pointer at its reset value and the first contended cycle favours load.
    assign arb_en              = rst_n && (state_q == ST_RUN);
    assign arb_req[REQ_LOAD]   = load_req;
    assign arb_req[REQ_FETCH]  = fetch_req;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        load_gnt  = 1'b0;
        fetch_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_BOOT: begin
                    load_gnt = load_req;
                    if (load_done) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    load_gnt  = arb_gnt[REQ_LOAD];
                    fetch_gnt = arb_gnt[REQ_FETCH];
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // Illegal accesses are still granted but never reach the memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_gnt) begin
            mem_addr  = load_addr[AW+1:2];
            mem_wdata = load_wdata;
            mem_en    = load_ok;
            mem_we    = load_ok;
        end else if (fetch_gnt) begin
            mem_addr = fetch_addr[AW+1:2];
            mem_en   = fetch_ok;
        end
    end

    always_comb begin
        pend_d     = fetch_gnt;
        pend_err_d = fetch_gnt && !fetch_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pend_q     <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign running      = (state_q == ST_RUN);
    assign fetch_rvalid = pend_q;
    assign fetch_err    = pend_q && pend_err_q;

    always_comb begin
        fetch_rdata = '0;
        if (pend_q) begin
            fetch_rdata = pend_err_q ? NOP_WORD : mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural model of
// the loader/fetch sharing rules and a simple word-addressed store.
module tb_imem_arbiter;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        load_req;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;
    logic        load_gnt;
    logic        load_done;
    logic        running;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_arbiter #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .fetch_err    (fetch_err),
        .load_req     (load_req),
        .load_addr    (load_addr),
        .load_wdata   (load_wdata),
        .load_gnt     (load_gnt),
        .load_done    (load_done),
        .running      (running),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro stand-in: synchronous read, one cycle latency.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model state
    bit          m_run;
    bit          m_fetch_turn;
    bit          m_pend;
    bit          m_pend_err;
    logic [31:0] m_pend_data;
    logic [31:0] words [int];

    logic        cap_lg, cap_fg, cap_en, cap_rvalid, cap_err, cap_running;
    logic [31:0] cap_rdata;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] stored(input logic [31:0] a);
        int idx = int'(a / 4);
        return words.exists(idx) ? words[idx] : 32'h0;
    endfunction

    task automatic step(input logic freq, input logic [31:0] faddr, input logic lreq,
                        input logic [31:0] laddr, input logic [31:0] lwdata, input logic ldone);
        bit          e_lg, e_fg, e_en, e_we;
        logic [31:0] e_rdata;
        fetch_req  = freq;
        fetch_addr = faddr;
        load_req   = lreq;
        load_addr  = laddr;
        load_wdata = lwdata;
        load_done  = ldone;
        #2;
        if (!m_run) begin
            e_lg = lreq;
            e_fg = 1'b0;
        end else if (lreq && freq) begin
            e_lg = !m_fetch_turn;
            e_fg = m_fetch_turn;
        end else begin
            e_lg = lreq;
            e_fg = freq;
        end
        e_en    = e_lg ? legal(laddr) : (e_fg ? legal(faddr) : 1'b0);
        e_we    = e_lg && legal(laddr);
        e_rdata = !m_pend ? 32'h0 : (m_pend_err ? NOP : m_pend_data);

        chk("load_gnt", load_gnt, e_lg);
        chk("fetch_gnt", fetch_gnt, e_fg);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("running", running, m_run);
        chk("rvalid", fetch_rvalid, m_pend);
        chk("err", fetch_err, m_pend && m_pend_err);
        chk("rdata", fetch_rdata, e_rdata);
        if (e_en) chk("mem_addr", mem_addr, ((e_lg ? laddr : faddr) / 4) % DEPTH);
        if (e_we) chk("mem_wdata", mem_wdata, lwdata);

        cap_lg = load_gnt; cap_fg = fetch_gnt; cap_en = mem_en;
        cap_rvalid = fetch_rvalid; cap_rdata = fetch_rdata; cap_err = fetch_err;
        cap_running = running;

        if (e_lg && legal(laddr)) words[int'(laddr / 4)] = lwdata;
        m_pend      = e_fg;
        m_pend_err  = e_fg && !legal(faddr);
        m_pend_data = (e_fg && legal(faddr)) ? stored(faddr) : 32'h0;
        if (m_run && (e_lg || e_fg)) m_fetch_turn = e_lg;
        if (!m_run && ldone) m_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Called at a falling edge; holds reset for one cycle with requests up.
    task automatic do_reset();
        rst_n     = 1'b0;
        fetch_req = 1'b1;
        load_req  = 1'b1;
        load_done = 1'b1;
        #2;
        chk("rst_load_gnt", load_gnt, 32'h0);
        chk("rst_fetch_gnt", fetch_gnt, 32'h0);
        chk("rst_mem_en", mem_en, 32'h0);
        chk("rst_mem_we", mem_we, 32'h0);
        chk("rst_running", running, 32'h0);
        chk("rst_rvalid", fetch_rvalid, 32'h0);
        chk("rst_err", fetch_err, 32'h0);
        chk("rst_rdata", fetch_rdata, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        fetch_req = 1'b0;
        load_req  = 1'b0;
        load_done = 1'b0;
        m_run = 1'b0; m_fetch_turn = 1'b0; m_pend = 1'b0; m_pend_err = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        logic [31:0] a = 32'($urandom_range(0, 15)) * 4;
        if (r == 0)      a = a + 32'($urandom_range(1, 3));
        else if (r == 1) a = $urandom | 32'(4 * DEPTH);
        return a;
    endfunction

    initial begin
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        load_req = 1'b0; load_addr = '0; load_wdata = '0; load_done = 1'b0;
        @(negedge clk);
        do_reset();

        // Load two words, finish the image, fetch them back.
        step(1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0093, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h4, 32'h0010_0113, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d1_gnt0", cap_fg, 32'h1);
        step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d1_gnt1", cap_fg, 32'h1);
        chk("d1_data0", cap_rdata, 32'h0000_0093);
        idle();
        chk("d1_rvalid1", cap_rvalid, 32'h1);
        chk("d1_data1", cap_rdata, 32'h0010_0113);

        // Fetch held off in BOOT until the image is complete.
        do_reset();
        step(1'b1, 32'h8, 1'b1, 32'h8, 32'hCAFE_0001, 1'b0);
        chk("d2_held0", cap_fg, 32'h0);
        step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("d2_held1", cap_fg, 32'h0);
        step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d2_gnt", cap_fg, 32'h1);
        idle();
        chk("d2_data", cap_rdata, 32'hCAFE_0001);

        // Contention from a fresh pointer: load, fetch, load, fetch.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0, 1'b1, 32'h40, 32'(i), 1'b0);
            chk("d3_rr_load", cap_lg, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("d3_rr_fetch", cap_fg, (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        idle();

        // Misaligned and out-of-range fetches.
        step(1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d4_en_mis", cap_en, 32'h0);
        step(1'b1, 32'(4 * DEPTH), 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d4_en_oor", cap_en, 32'h0);
        chk("d4_err_mis", cap_err, 32'h1);
        chk("d4_nop_mis", cap_rdata, NOP);
        idle();
        chk("d4_err_oor", cap_err, 32'h1);
        chk("d4_nop_oor", cap_rdata, NOP);

        // Reset with a fetch in flight.
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d5_gnt", cap_fg, 32'h1);
        do_reset();
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d5_no_rvalid", cap_rvalid, 32'h0);
        chk("d5_blocked", cap_fg, 32'h0);
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("d5_blocked2", cap_fg, 32'h0);
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d5_resumed", cap_fg, 32'h1);
        idle();

        // Final load together with load_done.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 32'h20, 32'h1234_5678, 1'b1);
        chk("d6_lgnt", cap_lg, 32'h1);
        chk("d6_not_run", cap_running, 32'h0);
        step(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("d6_run", cap_running, 32'h1);
        idle();
        chk("d6_data", cap_rdata, 32'h1234_5678);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int w = 0; w < 16; w++) step(1'b0, 32'h0, 1'b1, 32'(w * 4), $urandom, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) == 0,
                     rand_addr(), $urandom, $urandom_range(0, 15) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH, default 256, memory depth in 32-bit words; a power of two.
REQ-002 Parameter NOP_WORD, default 32'h00000013, data returned on a faulting fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fetch_req  input  1  fetch stage requests a read.
REQ-006 fetch_addr  input  32  byte address of the instruction.
REQ-007 fetch_gnt  output  1  fetch request accepted this cycle.
REQ-008 fetch_rvalid  output  1  fetch_rdata and fetch_err are valid.
REQ-009 fetch_rdata  output  32  fetched instruction.
REQ-010 fetch_err  output  1  accepted fetch was misaligned or out of range.
REQ-011 load_req  input  1  program loader requests a write.
REQ-012 load_addr  input  32  byte address of the write.
REQ-013 load_wdata  input  32  word to write.
REQ-014 load_gnt  output  1  write accepted this cycle.
REQ-015 load_done  input  1  single-cycle pulse: program image is complete.
REQ-016 running  output  1  high in the RUN state.
REQ-017 mem_en, mem_we  output  1 each  memory port enable and write enable.
REQ-018 mem_addr  output  log2(DEPTH)  word index (byte address bits [log2(DEPTH)+1:2]).
REQ-019 mem_wdata  output  32  write data; mem_rdata  input  32  read data, valid one cycle after a read with mem_en=1.

Function
REQ-020 FSM states: BOOT and RUN; BOOT -> RUN on load_done; RUN -> BOOT only on reset.
REQ-021 In BOOT: load_gnt = load_req; fetch_gnt = 0; fetch requests are held off, never dropped.
REQ-022 In RUN: at most one grant per cycle; when only one side requests, it is granted the same cycle (combinational gnt).
REQ-023 In RUN with both requesting: round-robin. The side not granted most recently wins. The pointer updates only on a grant.
REQ-024 Pointer after reset: load granted first.
REQ-025 A load grant drives mem_en=1, mem_we=1, mem_addr from load_addr and mem_wdata = load_wdata in the same cycle.
REQ-026 A fetch grant with a legal address drives mem_en=1 and mem_we=0. fetch_rvalid=1 exactly one cycle later, with fetch_rdata = mem_rdata and fetch_err = 0.
REQ-027 Illegal fetch: fetch_addr[1:0] != 0 or fetch_addr >= 4*DEPTH.
REQ-028 An illegal fetch is still granted, with mem_en=0. One cycle later: fetch_rvalid=1, fetch_rdata = NOP_WORD, fetch_err=1.
REQ-029 Loads with a misaligned or out-of-range address are granted and discarded (mem_en=0).
REQ-030 load_done together with load_req in BOOT: the load is granted; the state is RUN from the next cycle.
REQ-031 load_done in RUN is ignored.
REQ-032 Fetch throughput: back-to-back fetch grants every cycle when uncontended.

Reset
REQ-033 While rst_n=0 the outputs are: state BOOT, running=0, fetch_rvalid=0, fetch_err=0, fetch_rdata=0, all gnt=0, mem_en=0, mem_we=0, pointer=load.
REQ-034 Reset during an outstanding fetch: fetch_rvalid is not asserted for that fetch after rst_n releases.

Structure
REQ-035 Shared package imem_pkg holds the state enumeration (BOOT, RUN), the NOP_WORD default and the word-index width function.
REQ-036 One sub-module, rr_arb2: a 2-requester round-robin arbiter with a registered last-grant pointer.

Verification
REQ-037 Load 0x00000093 to address 0 and 0x00100113 to address 4, pulse load_done, fetch 0 then 4 -> rvalid on the cycle after each grant, with rdata 0x00000093 then 0x00100113.
REQ-038 Fetch 0x8 while in BOOT -> fetch_gnt=0 until the cycle after load_done, then rvalid with the stored word.
REQ-039 fetch_req and load_req held high for 4 cycles in RUN -> grants load, fetch, load, fetch.
REQ-040 Fetch 0x6, then fetch 4*DEPTH -> each gives rvalid, rdata=0x00000013, err=1, and mem_en=0 on the grant cycle.
REQ-041 Assert rst_n=0 on the cycle after a fetch grant -> no rvalid; running=0; a subsequent fetch is blocked until load_done.
REQ-042 load_req and load_done in the same BOOT cycle -> write performed; running=1 from the next cycle.
